lvds_tx: RTL and testbench
==========================

Name: lvds_tx

Overview:
Serial LVDS frame transmitter, the sending end of the board-to-board ADS data link. Collects WORDS 32-bit words from the PS/processing side into an internal frame buffer. When the buffer is full it serialises, MSB-first, one bit per lvds_clk: the 32-bit sync word "SFDK", then the words in load order, then an idle gap. The far-end deserializer sees one contiguous bit stream with no gap between sync and payload.

Parameters:
WORDS, 8, payload words per frame (power of 2, 2..16)
SYNC_WORD, 32'h5346444B, frame sync pattern ("SFDK"), sent bit 31 first
GAP_BITS, 32, zero bits forced after each frame, range 0..255; flushes the far-end shift register so payload cannot alias into a false sync

Ports:
lvds_clk  input  1  bit clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
wr_en  input  1  load strobe; a word is accepted when wr_en && wr_ready
wr_data  input  32  payload word to load
wr_ready  output  1  high only in IDLE; buffer accepts words
busy  output  1  high in SYNC, DATA and GAP
tx_done  output  1  one-cycle pulse on the first cycle after the last payload bit
lvds_data_out  output  1  registered serial line, low when not transmitting

Behaviour:
- Interface (decided): one clock, lvds_clk; reset rst is asynchronous and active-high.
- Reset values: wr_ready=1, busy=0, tx_done=0, lvds_data_out=0; state=IDLE; wr_ptr, bit_cnt, word_idx, gap_cnt=0. Buffer contents are don't-care.
- States: IDLE, SYNC, DATA, GAP.
- IDLE: an accepted word is stored at buffer[wr_ptr], and wr_ptr increments.
  - On the edge that stores word index WORDS-1: state<=SYNC, wr_ptr<=0, bit_cnt<=0, lvds_data_out<=SYNC_WORD[31].
  - A partial buffer waits indefinitely. There is no timeout and no flush.
- SYNC: on each edge, bit_cnt increments and lvds_data_out<=SYNC_WORD[30-bit_cnt].
  - On the edge with bit_cnt==31: state<=DATA, bit_cnt<=0, word_idx<=0, lvds_data_out<=buffer[0][31].
  - The SYNC state lasts exactly 32 cycles.
- DATA: lvds_data_out carries buffer[word_idx][31-bit_cnt].
  - bit_cnt wraps 31->0; word_idx increments on each wrap.
  - After the last bit of buffer[WORDS-1], state<=GAP and lvds_data_out<=0.
  - The DATA state lasts exactly WORDS*32 cycles, with no idle bit between words.
- GAP: lvds_data_out=0 for GAP_BITS cycles, then state<=IDLE.
  - If GAP_BITS==0, DATA goes directly to IDLE.
- tx_done is high for the single cycle after the last payload bit, i.e. the first GAP or IDLE cycle.
- wr_ready and busy are decoded from the registered state, so they are glitch-free. wr_ready = !busy.
- wr_en while wr_ready==0 is ignored: no store and no pointer change. The frame buffer stays stable throughout transmission.
- Minimum frame-to-frame period is 32 + WORDS*32 + GAP_BITS + WORDS cycles: 328 cycles at defaults.
- Reset asserted mid-frame: the line goes low immediately (asynchronous) and all counters clear. The partial frame and partially loaded buffer are discarded, and no tx_done pulse is produced.
- Counter widths: bit_cnt 5b; word_idx and wr_ptr $clog2(WORDS); gap_cnt 8b. All counters wrap or clear explicitly, never by overflow.
- Timing: data is launched on posedge. The bit/clock phase relationship at the far end (centre alignment) is owned by the IO/PHY constraints, not by this block.

Test Plan:
1. Reset with wr_en held high -> wr_ready=1, busy=0, lvds_data_out=0. No word is stored while rst=1.
2. Load 0x00000001..0x00000008 on consecutive cycles -> on the 8th load edge busy=1. Line then carries 32 bits of 0x5346444B MSB-first, followed by the eight words MSB-first over 256 cycles. tx_done pulses at cycle 289 after start, 32 zero bits follow, then wr_ready=1.
3. Load 5 words, idle 1000 cycles -> line stays 0 and busy=0. Load 3 more (0xA5A5A5A5, 0xFFFFFFFF, 0x00000000) -> frame sends all 8 in load order.
4. Pulse wr_en with 0xDEADBEEF during DATA -> word ignored, frame payload unchanged. The next frame needs 8 fresh loads after wr_ready returns.
5. Assert rst at DATA word 3, bit 10 -> line 0 in the same cycle, no tx_done. After release, a fresh 8-word load produces a correct complete frame.
6. Loopback into a bench deserializer hunting SYNC_WORD, over 100 back-to-back frames of random payload including words equal to 0x5346444B -> every frame recovered exactly, with no false sync in gaps or payload.

Source files
------------

// File: rtl/lvds_tx.sv
// Serial LVDS frame transmitter: buffers WORDS payload words, then sends
// sync word + payload MSB-first, one bit per lvds_clk, followed by an idle gap.
module lvds_tx #(
   parameter int unsigned WORDS     = 8,
   parameter logic [31:0] SYNC_WORD = 32'h5346444B,
   parameter int unsigned GAP_BITS  = 32
) (
   input  logic        lvds_clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   output logic        busy,
   output logic        tx_done,
   output logic        lvds_data_out
);

   localparam int unsigned PTR_W  = $clog2(WORDS);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BIT_W  = 5;
   localparam int unsigned GAP_W  = 8;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
   // Unreachable when GAP_BITS==0, since DATA then returns straight to IDLE
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0]   word_idx, word_idx_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt, bit_inc;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
   logic               data_nxt;
   logic               done_nxt;
   logic               store;
   logic [WORD_W-1:0]  buffer [WORDS];

   // Frame buffer; contents are don't-care after reset, so no reset term
   always_ff @(posedge lvds_clk) begin
      if (store) begin
         buffer[wr_ptr] <= wr_data;
      end
   end

   // Next-state, counter and serial-bit selection
   always_comb begin
      state_nxt    = state;
      wr_ptr_nxt   = wr_ptr;
      word_idx_nxt = word_idx;
      bit_cnt_nxt  = bit_cnt;
      gap_cnt_nxt  = gap_cnt;
      data_nxt     = 1'b0;
      done_nxt     = 1'b0;
      store        = 1'b0;
      bit_inc      = bit_cnt + BIT_W'(1);

      case (state)
         IDLE: begin
            if (wr_en) begin
               store = 1'b1;
               if (wr_ptr == LAST_PTR) begin
                  state_nxt   = SYNC;
                  wr_ptr_nxt  = '0;
                  bit_cnt_nxt = '0;
                  data_nxt    = SYNC_WORD[WORD_W-1];
               end else begin
                  wr_ptr_nxt = wr_ptr + PTR_W'(1);
               end
            end
         end

         SYNC: begin
            if (bit_cnt == LAST_BIT) begin
               state_nxt    = DATA;
               bit_cnt_nxt  = '0;
               word_idx_nxt = '0;
               data_nxt     = buffer[0][WORD_W-1];
            end else begin
               // ~bit_inc == 31 - (bit_cnt + 1): the next bit, MSB-first
               bit_cnt_nxt = bit_inc;
               data_nxt    = SYNC_WORD[~bit_inc];
            end
         end

         DATA: begin
            if (bit_cnt == LAST_BIT) begin
               bit_cnt_nxt = '0;
               if (word_idx == LAST_PTR) begin
                  done_nxt     = 1'b1;
                  word_idx_nxt = '0;
                  gap_cnt_nxt  = '0;
                  state_nxt    = (GAP_BITS == 0) ? IDLE : GAP;
               end else begin
                  word_idx_nxt = word_idx + PTR_W'(1);
                  data_nxt     = buffer[word_idx_nxt][WORD_W-1];
               end
            end else begin
               bit_cnt_nxt = bit_inc;
               data_nxt    = buffer[word_idx][~bit_inc];
            end
         end

         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt   = IDLE;
               gap_cnt_nxt = '0;
            end else begin
               gap_cnt_nxt = gap_cnt + GAP_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and all outputs registered; reset drops the line at once
   always_ff @(posedge lvds_clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         word_idx      <= '0;
         bit_cnt       <= '0;
         gap_cnt       <= '0;
         lvds_data_out <= 1'b0;
         tx_done       <= 1'b0;
         wr_ready      <= 1'b1;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         wr_ptr        <= wr_ptr_nxt;
         word_idx      <= word_idx_nxt;
         bit_cnt       <= bit_cnt_nxt;
         gap_cnt       <= gap_cnt_nxt;
         lvds_data_out <= data_nxt;
         tx_done       <= done_nxt;
         wr_ready      <= (state_nxt == IDLE);
         busy          <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_lvds_tx.sv
// Directed bench for lvds_tx: frame format/timing, partial loads, ignored writes,
// mid-frame reset and a 100-frame loopback through a sync-hunting deserializer.
module tb_lvds_tx;

   localparam int unsigned WORDS = 8;
   localparam int unsigned GAP   = 32;
   localparam logic [31:0] SYNC  = 32'h5346444B;

   logic        lvds_clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        busy;
   logic        tx_done;
   logic        lvds_data_out;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_w    [WORDS];
   logic [31:0] rx_words [WORDS];
   logic [31:0] rx_sync;
   int          early_done;
   int          inject_at = -1;

   // loopback deserializer state
   logic        des_en = 1'b0;
   logic        des_rx;
   logic [31:0] des_sh;
   logic [31:0] des_word;
   int          des_cnt;
   int          sync_hits;
   logic [31:0] rx_q  [$];
   logic [31:0] exp_q [$];

   always #5 lvds_clk = ~lvds_clk;

   lvds_tx #(.WORDS(WORDS), .SYNC_WORD(SYNC), .GAP_BITS(GAP)) dut (
      .lvds_clk      (lvds_clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .busy          (busy),
      .tx_done       (tx_done),
      .lvds_data_out (lvds_data_out)
   );

   always @(negedge lvds_clk) begin
      if (des_en) begin
         if (!des_rx) begin
            des_sh = {des_sh[30:0], lvds_data_out};
            if (des_sh == SYNC) begin
               des_rx  = 1'b1;
               des_cnt = 0;
               sync_hits++;
            end
         end else begin
            des_sh   = {des_sh[30:0], lvds_data_out};
            des_word = {des_word[30:0], lvds_data_out};
            des_cnt++;
            if (des_cnt % 32 == 0) rx_q.push_back(des_word);
            if (des_cnt == WORDS * 32) des_rx = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge lvds_clk);
      wr_en   = 1'b0;
   endtask

   task automatic load_range(input int first, input int last);
      for (int k = first; k <= last; k++) load(exp_w[k]);
   endtask

   // Called on the negedge showing the first sync bit; captures sync + payload,
   // then checks tx_done, the gap and the return to IDLE.
   task automatic run_frame(input string tag);
      int ones, rdy, extra, idx;
      early_done = 0;
      for (int i = 0; i < 32; i++) begin
         rx_sync = {rx_sync[30:0], lvds_data_out};
         early_done += int'(tx_done);
         @(negedge lvds_clk);
      end
      for (int k = 0; k < WORDS; k++) begin
         for (int i = 0; i < 32; i++) begin
            idx = 32 + k * 32 + i;
            rx_words[k] = {rx_words[k][30:0], lvds_data_out};
            early_done += int'(tx_done);
            if (idx == inject_at) begin
               wr_en   = 1'b1;
               wr_data = 32'hDEADBEEF;
            end else begin
               wr_en = 1'b0;
            end
            @(negedge lvds_clk);
         end
      end
      wr_en = 1'b0;
      check($sformatf("%s:sync", tag), rx_sync, SYNC);
      for (int k = 0; k < WORDS; k++)
         check($sformatf("%s:word%0d", tag, k), rx_words[k], exp_w[k]);
      check($sformatf("%s:early_done", tag), 32'(early_done), 32'd0);
      check($sformatf("%s:done_pulse", tag), 32'(tx_done), 32'd1);
      ones = 0; rdy = 0; extra = 0;
      for (int i = 0; i < GAP; i++) begin
         ones += int'(lvds_data_out);
         rdy  += int'(wr_ready);
         if (i > 0) extra += int'(tx_done);
         @(negedge lvds_clk);
      end
      check($sformatf("%s:gap_ones", tag), 32'(ones), 32'd0);
      check($sformatf("%s:gap_ready", tag), 32'(rdy), 32'd0);
      check($sformatf("%s:gap_done", tag), 32'(extra), 32'd0);
      check($sformatf("%s:ready_after", tag), 32'(wr_ready), 32'd1);
      check($sformatf("%s:busy_after", tag), 32'(busy), 32'd0);
   endtask

   initial begin
      int ones, bsy, dn, n;
      logic [31:0] w [WORDS];

      // 1: reset with wr_en held high
      rst = 1'b1; wr_en = 1'b1; wr_data = 32'hBAD0BAD0;
      repeat (3) @(negedge lvds_clk);
      check("rst:wr_ready", 32'(wr_ready), 32'd1);
      check("rst:busy", 32'(busy), 32'd0);
      check("rst:line", 32'(lvds_data_out), 32'd0);
      check("rst:tx_done", 32'(tx_done), 32'd0);
      wr_en = 1'b0; rst = 1'b0;
      @(negedge lvds_clk);

      // 2: basic frame of 1..8
      exp_w = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
      load_range(0, 6);
      check("t2:ready_before_last", 32'(wr_ready), 32'd1);
      load(exp_w[7]);
      check("t2:busy_start", 32'(busy), 32'd1);
      check("t2:ready_start", 32'(wr_ready), 32'd0);
      run_frame("t2");

      // 3: partial buffer waits, then completes
      exp_w = '{32'h11111111, 32'h22222222, 32'h80000001, 32'h12345678, 32'h5346444B,
                32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000000};
      load_range(0, 4);
      ones = 0; bsy = 0;
      repeat (1000) begin
         ones += int'(lvds_data_out);
         bsy  += int'(busy);
         @(negedge lvds_clk);
      end
      check("t3:idle_line", 32'(ones), 32'd0);
      check("t3:idle_busy", 32'(bsy), 32'd0);
      load_range(5, 7);
      check("t3:busy_start", 32'(busy), 32'd1);
      run_frame("t3");

      // 4: write during DATA is ignored
      exp_w = '{32'hCAFEF00D, 32'h0F0F0F0F, 32'h13579BDF, 32'h2468ACE0, 32'h7FFFFFFE,
                32'h00010000, 32'hFEDCBA98, 32'h55AA55AA};
      load_range(0, 7);
      inject_at = 100;
      run_frame("t4a");
      inject_at = -1;
      exp_w = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505,
                32'h06060606, 32'h07070707, 32'h08080808};
      load_range(0, 6);
      repeat (5) @(negedge lvds_clk);
      check("t4b:not_started", 32'(busy), 32'd0);
      load(exp_w[7]);
      check("t4b:busy_start", 32'(busy), 32'd1);
      run_frame("t4b");

      // 5: reset at DATA word 3, bit 10
      exp_w = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
      load_range(0, 7);
      repeat (138) @(negedge lvds_clk);
      check("t5:line_before_rst", 32'(lvds_data_out), 32'd1);
      rst = 1'b1;
      #1;
      check("t5:line_async", 32'(lvds_data_out), 32'd0);
      check("t5:busy_async", 32'(busy), 32'd0);
      check("t5:ready_async", 32'(wr_ready), 32'd1);
      check("t5:done_async", 32'(tx_done), 32'd0);
      @(negedge lvds_clk);
      rst = 1'b0;
      ones = 0; bsy = 0; dn = 0;
      repeat (400) begin
         ones += int'(lvds_data_out);
         bsy  += int'(busy);
         dn   += int'(tx_done);
         @(negedge lvds_clk);
      end
      check("t5:post_line", 32'(ones), 32'd0);
      check("t5:post_busy", 32'(bsy), 32'd0);
      check("t5:post_done", 32'(dn), 32'd0);
      exp_w = '{32'h9ABCDEF0, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                32'h0BADCAFE, 32'h5346444B, 32'hC0FFEE00};
      load_range(0, 6);
      check("t5:fresh_not_started", 32'(busy), 32'd0);
      load(exp_w[7]);
      check("t5:busy_start", 32'(busy), 32'd1);
      run_frame("t5");

      // 6: loopback of 100 back-to-back random frames
      des_rx = 1'b0; des_sh = '0; des_word = '0; des_cnt = 0; sync_hits = 0;
      des_en = 1'b1;
      for (int f = 0; f < 100; f++) begin
         for (int k = 0; k < WORDS; k++) w[k] = $urandom();
         if (f % 10 == 0) w[f % 8] = SYNC;
         if (f % 10 == 5) begin w[3] = 32'h00005346; w[4] = 32'h444B0000; end
         if (f % 10 == 7) w[7] = SYNC;
         n = 0;
         while (!wr_ready && n < 2000) begin
            @(negedge lvds_clk);
            n++;
         end
         if (!wr_ready) begin
            check("t6:ready_timeout", 32'(wr_ready), 32'd1);
            break;
         end
         for (int k = 0; k < WORDS; k++) begin
            exp_q.push_back(w[k]);
            load(w[k]);
         end
      end
      repeat (400) @(negedge lvds_clk);
      des_en = 1'b0;
      check("t6:word_count", 32'(rx_q.size()), 32'(exp_q.size()));
      check("t6:sync_hits", 32'(sync_hits), 32'd100);
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("t6:f%0d_w%0d", i / WORDS, i % WORDS), rx_q[i], exp_q[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
